// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered one-hot grants held while the owner keeps requesting.
// Define RR_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD contended cycles.
module rr_hold_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 busy_o
);

  if (NUM_PORTS < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_hold_arbiter: NUM_PORTS must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 new_grant;
  logic                 owner_req;
  logic                 others_req;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // Rotating first-set search starting at ptr, wrapping NUM_PORTS-1 -> 0.
  function automatic logic [NUM_PORTS-1:0] arb(input logic [NUM_PORTS-1:0] r,
                                               input logic [IDX_W-1:0]     p);
    logic [NUM_PORTS-1:0] g;
    logic                 found;
    int unsigned          k;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < int'(NUM_PORTS); i++) begin
      k = (int'(p) + i) % int'(NUM_PORTS);
      if (!found && r[k]) begin
        g[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IDX_W-1:0] enc(input logic [NUM_PORTS-1:0] g);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < int'(NUM_PORTS); i++) begin
      if (g[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    new_grant  = 1'b0;
    owner_req  = |(req_i & gnt_q);
    others_req = |(req_i & ~gnt_q);
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = GRANT;
          gnt_d     = arb(req_i, ptr_q);
          new_grant = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d    = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        if (owner_req) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (hold_q == HOLD_W'(MAX_HOLD) && others_req) begin
            gnt_d     = arb(req_i & ~gnt_q, ptr_q);
            new_grant = 1'b1;
            hold_d    = HOLD_W'(1);
          end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d    = hold_q + HOLD_W'(1);
          end
`endif
        end else if (others_req) begin
          // Owner bit is already low, so it naturally loses this arbitration.
          gnt_d     = arb(req_i, ptr_q);
          new_grant = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d    = HOLD_W'(1);
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    ptr_d = ptr_q;
    if (new_grant) begin
      if (enc(gnt_d) == IDX_W'(NUM_PORTS - 1)) ptr_d = '0;
      else                                     ptr_d = enc(gnt_d) + IDX_W'(1);
    end
  end

  always_comb begin
    gnt_o     = gnt_q;
    gnt_idx_o = enc(gnt_q);
    busy_o    = |gnt_q;
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter (NUM_PORTS=4, MAX_HOLD=4): driver queues expected
// grants per cycle, monitor pops and compares after each edge and on async reset.
module tb_rr_hold_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req_i   = '0;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         busy_o;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_hold_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .busy_o    (busy_o)
  );

  function automatic exp_t mk(input logic [3:0] g);
    exp_t e;
    e.gnt  = g;
    e.busy = (g != 4'b0000);
    case (g)
      4'b0010: e.idx = 2'd1;
      4'b0100: e.idx = 2'd2;
      4'b1000: e.idx = 2'd3;
      default: e.idx = 2'd0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the grant expected after the next rise.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    reset_n = rst;
    req_i   = r;
    exp_q.push_back(mk(g));
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    exp_q.push_back(mk(4'b0000));
    reset_n = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",    int'(gnt_o),     int'(e.gnt));
        check("idx",    int'(gnt_idx_o), int'(e.idx));
        check("busy",   int'(busy_o),    int'(e.busy));
        check("onehot", int'($onehot0(gnt_o)), 1);
      end
    end
  end

  initial begin : driver
    logic [3:0] g;
    // Reset and first grant
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0001);
    // Fair rotation, no idle bubbles
    step(1'b1, 4'b1110, 4'b0010);
    step(1'b1, 4'b1101, 4'b0100);
    step(1'b1, 4'b1011, 4'b1000);
    step(1'b1, 4'b0111, 4'b0001);
    // Wrap-around: port 0 beats port 3 after port 3's grant ends
    step(1'b1, 4'b1000, 4'b1000);
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b1001, 4'b0001);
    step(1'b1, 4'b0000, 4'b0000);
    // Park ptr at 0 for the hold-limit test
    step(1'b1, 4'b1000, 4'b1000);
    step(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 12; i++) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
      g = (((i / MH) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
      g = 4'b0001;
`endif
      step(1'b1, 4'b0011, g);
    end
    step(1'b1, 4'b0000, 4'b0000);
    // Sole requester holds indefinitely
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0100, 4'b0100);
    // Async reset mid-grant
    step(1'b1, 4'b0010, 4'b0010);
    step(1'b1, 4'b0010, 4'b0010);
    async_reset();
    step(1'b0, 4'b1010, 4'b0000);
    step(1'b1, 4'b1010, 4'b0010);
    step(1'b1, 4'b1010, 4'b0010);
    step(1'b1, 4'b1000, 4'b1000);
    step(1'b1, 4'b0000, 4'b0000);

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
Parametrised round-robin arbiter that replaces the fixed-priority scheme with fair rotation and registered grants.
- Holds a grant while the owner keeps requesting.
- Optionally forces rotation after a bounded number of cycles.
- Sits in front of shared resources (bus or memory ports) where a requester needs a multi-cycle ownership window.
- Reset-time priority matches the fixed scheme: port 0 highest.

Parameters:
NUM_PORTS, 4, number of requesters (>= 2)
MAX_HOLD, 8, max consecutive grant cycles per owner when others are pending (>= 1; used only with the optional feature)
IDX_W, $clog2(NUM_PORTS), width of the grant index (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_i  input  NUM_PORTS  request vector, level-sensitive, one bit per port
gnt_o  output  NUM_PORTS  registered one-hot grant, all-zero when idle
gnt_idx_o  output  IDX_W  binary index of the current owner; 0 when idle
busy_o  output  1  high while any grant is held (OR of gnt_o)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Port names are clk and reset_n.
- Reset (reset_n low, immediate):
  - gnt_o=0, gnt_idx_o=0, busy_o=0.
  - Round-robin pointer ptr=0, hold counter hold_cnt=0, state IDLE.
  - Reset asserted mid-grant drops the grant in the same cycle with no clock edge; the interrupted owner gets no credit.
- Arbitration function (combinational), applied to a request vector R:
  - Search R starting at index ptr, ascending, wrapping NUM_PORTS-1 -> 0.
  - The first set bit wins; the result is one-hot or zero.
- ptr update: whenever a new grant is issued to port k, ptr <= (k+1) mod NUM_PORTS. ptr is unchanged otherwise.
- State machine (updates on the rising edge):
  - IDLE, req_i==0: stay IDLE, outputs 0.
  - IDLE, req_i!=0: go to GRANT. gnt_o <= arb(req_i), hold_cnt <= 1. Latency from request to grant is 1 cycle.
  - GRANT, owner bit of req_i high, no forced release: keep gnt_o, hold_cnt <= min(hold_cnt+1, MAX_HOLD).
  - GRANT, owner bit of req_i low:
    - if other requests are pending, gnt_o <= arb(req_i) and hold_cnt <= 1, with no idle bubble;
    - otherwise go to IDLE and gnt_o <= 0.
  - The owner sees its grant high during the cycle in which it deasserts req; the grant drops at the next edge.
- Owner eligibility: when the owner's grant ends, the owner is lowest priority for the next arbitration, because ptr already points past it.
- No grant is ever issued to a port whose req_i bit is low at the deciding edge.
- Single requester: holds the grant indefinitely. hold_cnt saturates at MAX_HOLD with no wrap-around.
- Invariants:
  - gnt_o is always zero or one-hot.
  - gnt_idx_o is consistent with gnt_o.
  - busy_o == |gnt_o.
- A new request arriving in the same cycle as the owner's release competes in that cycle's arbitration.

Optional Feature:
Macro: RR_ARB_HOLD_LIMIT_EN
- Defined: forced release. In GRANT, if hold_cnt==MAX_HOLD, the owner's req is still high, and any other req_i bit is high, then at that edge:
  - gnt_o <= arb(req_i with owner masked off);
  - hold_cnt <= 1;
  - ptr advances as normal.
  - Each owner therefore gets at most MAX_HOLD consecutive cycles while contended.
  - With no contention, the owner holds indefinitely.
- Not defined: no forced release. The grant is held as long as the owner's req is high. The hold counter logic may be removed; behaviour otherwise identical.

Test Plan:
1. Reset and first grant (NUM_PORTS=4):
   - Stimulus: req_i=4'b1111 during reset, reset_n released.
   - Response: gnt_o=0 while in reset; after the first edge gnt_o=4'b0001, gnt_idx_o=0, busy_o=1.
2. Fair rotation:
   - Stimulus: req_i=4'b1111; each owner drops its req one cycle after seeing its grant, then re-raises it.
   - Response: gnt_o sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles between grants.
3. Wrap-around:
   - Stimulus: after a grant to port 3 ends, req_i=4'b1001.
   - Response: next gnt_o=4'b0001 (port 0 before port 3).
4. Hold limit (MAX_HOLD=4):
   - Stimulus: req_i=4'b0011 held constant.
   - Response with macro: gnt_o=0001 for exactly 4 cycles, then 0010 for 4 cycles, alternating.
   - Response without macro: gnt_o=0001 permanently.
5. Sole requester saturation:
   - Stimulus: req_i=4'b0100 for 20 cycles, macro defined.
   - Response: gnt_o=0100 for all cycles, hold_cnt stays at 4, no drop.
6. Async reset mid-grant:
   - Stimulus: while gnt_o=0010, pull reset_n low between edges; release it with req_i=4'b1010.
   - Response: gnt_o goes to 0 immediately on reset; after release the first grant is 0010 (ptr back to 0, so port 1 beats port 3).
